// File: rtl/hpdcache_mem_responder.sv
// hpdcache_mem_responder: behavioural memory target for the HPDcache memory interface.
// Independent read and write FSMs over a byte-maskable word array.
package hpdcache_mem_pkg;
    localparam int HPDCACHE_MEM_DATA_WIDTH = 512;
    localparam int HPDCACHE_MEM_TID_WIDTH  = 8;
    localparam int HPDCACHE_MEM_ADDR_WIDTH = 64;

    typedef enum logic [1:0] {
        HPDCACHE_MEM_READ   = 2'd0,
        HPDCACHE_MEM_WRITE  = 2'd1,
        HPDCACHE_MEM_ATOMIC = 2'd2
    } hpdcache_mem_command_e;

    typedef struct packed {
        logic [HPDCACHE_MEM_ADDR_WIDTH-1:0] addr;
        logic [7:0]                         len;
        logic [HPDCACHE_MEM_TID_WIDTH-1:0]  id;
        hpdcache_mem_command_e              command;
    } hpdcache_mem_req_t;

    typedef struct packed {
        logic                               error;
        logic [HPDCACHE_MEM_TID_WIDTH-1:0]  id;
        logic [HPDCACHE_MEM_DATA_WIDTH-1:0] data;
        logic                               last;
    } hpdcache_mem_resp_r_t;

    typedef struct packed {
        logic [HPDCACHE_MEM_DATA_WIDTH-1:0]   data;
        logic [HPDCACHE_MEM_DATA_WIDTH/8-1:0] be;
        logic                                 last;
    } hpdcache_mem_req_w_t;

    typedef struct packed {
        logic                              is_atomic;
        logic                              error;
        logic [HPDCACHE_MEM_TID_WIDTH-1:0] id;
    } hpdcache_mem_resp_w_t;
endpackage

module hpdcache_mem_responder
    import hpdcache_mem_pkg::*;
#(
    parameter int MEM_DEPTH  = 256,
    parameter int DATA_WIDTH = HPDCACHE_MEM_DATA_WIDTH,
    parameter int ID_WIDTH   = HPDCACHE_MEM_TID_WIDTH
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 mem_req_read_valid_i,
    output logic                 mem_req_read_ready_o,
    input  hpdcache_mem_req_t    mem_req_read_i,
    output logic                 mem_resp_read_valid_o,
    input  logic                 mem_resp_read_ready_i,
    output hpdcache_mem_resp_r_t mem_resp_read_o,
    input  logic                 mem_req_write_valid_i,
    output logic                 mem_req_write_ready_o,
    input  hpdcache_mem_req_t    mem_req_write_i,
    input  logic                 mem_req_write_data_valid_i,
    output logic                 mem_req_write_data_ready_o,
    input  hpdcache_mem_req_w_t  mem_req_write_data_i,
    output logic                 mem_resp_write_valid_o,
    input  logic                 mem_resp_write_ready_i,
    output hpdcache_mem_resp_w_t mem_resp_write_o
);
    localparam int BW  = DATA_WIDTH / 8;
    localparam int OFF = $clog2(BW);
    localparam int MAW = MEM_DEPTH > 1 ? $clog2(MEM_DEPTH) : 1;

    typedef logic [HPDCACHE_MEM_ADDR_WIDTH-1:0] idx_t;
    typedef enum logic {R_IDLE, R_BURST} r_state_e;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    r_state_e             r_state_q, r_state_d;
    idx_t                 r_idx_q, r_idx_d, r_ld_idx;
    logic [7:0]           r_left_q, r_left_d;
    hpdcache_mem_resp_r_t r_resp_q, r_resp_d;
    logic                 r_in;
    logic [DATA_WIDTH-1:0] r_data;

    w_state_e             w_state_q, w_state_d;
    idx_t                 w_idx_q, w_idx_d;
    logic [ID_WIDTH-1:0]  w_id_q, w_id_d;
    logic                 w_wr_q, w_wr_d, w_err_q, w_err_d, w_in, w_we;

    logic unused_fields;
    assign unused_fields = ^{mem_req_read_i.command, mem_req_write_i.len};

    // The next beat is loaded from the array at the same edge a write may land,
    // so a coincident write is not visible until the following load.
    always_comb begin
        r_state_d = r_state_q;
        r_idx_d   = r_idx_q;
        r_left_d  = r_left_q;
        r_resp_d  = r_resp_q;
        r_ld_idx  = r_state_q == R_IDLE ? mem_req_read_i.addr >> OFF : r_idx_q + idx_t'(1);
        r_in      = r_ld_idx < idx_t'(MEM_DEPTH);
        r_data    = r_in ? mem[r_ld_idx[MAW-1:0]] : '0;
        if (r_state_q == R_IDLE && mem_req_read_valid_i) begin
            r_state_d = R_BURST;
            r_idx_d   = r_ld_idx;
            r_left_d  = mem_req_read_i.len;
            r_resp_d  = '{error: !r_in, id: mem_req_read_i.id, data: r_data,
                          last: mem_req_read_i.len == 8'd0};
        end else if (r_state_q == R_BURST && mem_resp_read_ready_i) begin
            if (r_resp_q.last) begin
                r_state_d = R_IDLE;
                r_resp_d  = '0;
            end else begin
                r_idx_d  = r_ld_idx;
                r_left_d = r_left_q - 8'd1;
                r_resp_d = '{error: !r_in, id: r_resp_q.id, data: r_data, last: r_left_q == 8'd1};
            end
        end
    end

    always_comb begin
        w_state_d = w_state_q;
        w_idx_d   = w_idx_q;
        w_id_d    = w_id_q;
        w_wr_d    = w_wr_q;
        w_err_d   = w_err_q;
        w_in      = w_idx_q < idx_t'(MEM_DEPTH);
        w_we      = 1'b0;
        if (w_state_q == W_IDLE && mem_req_write_valid_i) begin
            w_state_d = W_DATA;
            w_idx_d   = mem_req_write_i.addr >> OFF;
            w_id_d    = mem_req_write_i.id;
            w_wr_d    = mem_req_write_i.command == HPDCACHE_MEM_WRITE;
            w_err_d   = mem_req_write_i.command != HPDCACHE_MEM_WRITE;
        end else if (w_state_q == W_DATA && mem_req_write_data_valid_i) begin
            w_we      = w_wr_q && w_in;
            w_err_d   = w_err_q || !w_in;
            w_idx_d   = w_idx_q + idx_t'(1);
            w_state_d = mem_req_write_data_i.last ? W_RESP : W_DATA;
        end else if (w_state_q == W_RESP && mem_resp_write_ready_i) begin
            w_state_d = W_IDLE;
            w_err_d   = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state_q <= R_IDLE;
            r_idx_q   <= '0;
            r_left_q  <= '0;
            r_resp_q  <= '0;
            w_state_q <= W_IDLE;
            w_idx_q   <= '0;
            w_id_q    <= '0;
            w_wr_q    <= 1'b0;
            w_err_q   <= 1'b0;
        end else begin
            r_state_q <= r_state_d;
            r_idx_q   <= r_idx_d;
            r_left_q  <= r_left_d;
            r_resp_q  <= r_resp_d;
            w_state_q <= w_state_d;
            w_idx_q   <= w_idx_d;
            w_id_q    <= w_id_d;
            w_wr_q    <= w_wr_d;
            w_err_q   <= w_err_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_we) begin
            for (int i = 0; i < BW; i++) begin
                if (mem_req_write_data_i.be[i]) mem[w_idx_q[MAW-1:0]][8*i +: 8] <= mem_req_write_data_i.data[8*i +: 8];
            end
        end
    end

    assign mem_req_read_ready_o       = r_state_q == R_IDLE;
    assign mem_resp_read_valid_o      = r_state_q == R_BURST;
    assign mem_resp_read_o            = r_resp_q;
    assign mem_req_write_ready_o      = w_state_q == W_IDLE;
    assign mem_req_write_data_ready_o = w_state_q == W_DATA;
    assign mem_resp_write_valid_o     = w_state_q == W_RESP;
    assign mem_resp_write_o = '{is_atomic: 1'b0, error: mem_resp_write_valid_o && w_err_q,
                                id: mem_resp_write_valid_o ? w_id_q : '0};
endmodule
